reg_countdown_seq: RTL
======================

Name: reg_countdown_seq

Overview:
Sequencer that consumes the 16x8 register file. It walks addresses 0..15 in order. For each address it reads the stored value and counts it down to zero at a prescaled tick rate. Each decremented value is written back into the same register. It also drives the live count, with its address, to the display path.

Parameters:
NUM_REGS, 16, number of registers walked (addresses 0..NUM_REGS-1)
DATA_W, 8, register data width
ADDR_W, 4, register address width
TICK_DIV, 100000000, Clk cycles per countdown tick (1 s at 100 MHz); must be >= 2

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  asynchronous, active-high reset
Start  in  1  level; sampled in IDLE only, begins a full walk
Pause  in  1  level; freezes prescaler and countdown while high
R_Addr  out  ADDR_W  read address to register file (= current index)
R_en  out  1  read enable to register file
R_Data  in  DATA_W  combinational read data from register file
W_Addr  out  ADDR_W  write-back address
W_en  out  1  write-back enable, single-cycle pulse
W_Data  out  DATA_W  write-back data
Count  out  DATA_W  live countdown value for display
Cur_Addr  out  ADDR_W  index currently being counted
Busy  out  1  high in any state except IDLE
Reg_Done  out  1  one-cycle pulse when an index reaches zero or is skipped
All_Done  out  1  one-cycle pulse after the last index completes

Behaviour:
- Reset is asynchronous and active-high. It clears state to IDLE and clears the index, prescaler, Count, W_en, W_Addr, W_Data, Reg_Done and All_Done to 0.
- Because R_en is decoded from state, R_en=0 in reset.
- On Rst assertion mid-operation, the walk aborts immediately with no further write.
- After Rst release the block waits in IDLE for Start.
- States are IDLE, READ, COUNT, NEXT, FINISH.
- IDLE: index=0. Start=1 -> READ.
- READ: lasts one cycle; R_en=1, R_Addr=index. At the clock edge Count<=R_Data and the prescaler clears.
  - R_Data==0 -> NEXT, with no write.
  - Otherwise -> COUNT.
- COUNT: the prescaler increments each cycle while Pause=0 and holds while Pause=1.
  - At prescaler==TICK_DIV-1 a tick fires and the prescaler wraps to 0.
  - On tick: Count<=Count-1. The next cycle has W_en=1, W_Addr=index, W_Data=Count-1 (registered, exactly one cycle).
  - When the new Count equals 0 -> NEXT.
  - The first tick occurs TICK_DIV unpaused cycles after entering COUNT.
- NEXT: lasts one cycle; Reg_Done=1.
  - index==NUM_REGS-1 -> FINISH.
  - Otherwise index<=index+1 -> READ.
- FINISH: lasts one cycle; All_Done=1. Then -> IDLE with index=0.
- R_en is 0 in every state except READ; R_Addr always equals index.
- Start while Busy is ignored.
- Start held high through FINISH restarts the walk from index 0 on the cycle after returning to IDLE.
- Pause asserted in READ or NEXT has no effect; those states always advance.
- The final write of 0 for an index and the transition to NEXT occur together: W_en is high in the first NEXT cycle.
- Count holds its last value (0) through NEXT/FINISH/IDLE until the next READ.
- All arithmetic is unsigned; Count never wraps below 0.
- Cur_Addr = index.

Decomposition:
- Shared package holds:
  - state enum (IDLE, READ, COUNT, NEXT, FINISH)
  - NUM_REGS, DATA_W and ADDR_W constants
  - the prescaler width function (clog2 of TICK_DIV)
- One natural sub-module, tick_prescaler:
  - inputs: clear, enable, TICK_DIV
  - output: a single-cycle tick
  - shared with other timed blocks in the design

Test Plan:
- Reset mid-COUNT: TICK_DIV=4, Rst pulsed asynchronously between edges -> all outputs 0 immediately, state IDLE, no W_en afterward until a new Start.
- Basic walk: TICK_DIV=4, bench regfile model reg0=3 -> R_en pulse with R_Addr=0, then W_en with W_Data=2,1,0 at 4-cycle spacing; Reg_Done after the write of 0; R_en with R_Addr=1 on the following cycle.
- Zero skip: reg1=0 -> READ then NEXT with no W_en; Reg_Done 1 cycle after R_en; Count=0.
- Pause: reg2=2, Pause high 10 cycles mid-COUNT -> tick spacing grows by exactly 10 cycles; Count unchanged during Pause.
- Full completion: regs 0..15 =1 each, TICK_DIV=2 -> 16 writes of 0, 16 Reg_Done pulses, one All_Done, then Busy=0 and R_Addr=0.

Source files
------------

// File: rtl/reg_countdown_seq_pkg.sv
// Shared types and constants for the register countdown sequencer and its helpers.
package reg_countdown_seq_pkg;

    localparam int NUM_REGS      = 16;
    localparam int DATA_W        = 8;
    localparam int ADDR_W        = 4;
    localparam int TICK_DIV_DFLT = 100_000_000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_COUNT,
        ST_NEXT,
        ST_FINISH
    } state_e;

    // Prescaler counter width; never narrower than one bit.
    function automatic int presc_w(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/reg_countdown_seq_if.sv
// Register-file access bus: one combinational read port, one registered write port.
interface reg_countdown_seq_if #(
    parameter int ADDR_W = reg_countdown_seq_pkg::ADDR_W,
    parameter int DATA_W = reg_countdown_seq_pkg::DATA_W
);
    logic [ADDR_W-1:0] R_Addr;
    logic              R_en;
    logic [DATA_W-1:0] R_Data;
    logic [ADDR_W-1:0] W_Addr;
    logic              W_en;
    logic [DATA_W-1:0] W_Data;

    modport master (
        output R_Addr, R_en, W_Addr, W_en, W_Data,
        input  R_Data
    );

    modport slave (
        input  R_Addr, R_en, W_Addr, W_en, W_Data,
        output R_Data
    );
endinterface

// File: rtl/reg_countdown_seq_tick_prescaler.sv
// Free-running divide-by-TICK_DIV counter with clear and pause; emits a one-cycle tick.
module tick_prescaler
    import reg_countdown_seq_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DFLT
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int              CNT_W = presc_w(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick = enable && (cnt_q == LAST);

    // Count enabled cycles, wrapping on the tick; clear takes priority.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/reg_countdown_seq.sv
// Walks every register, counting each stored value down to zero at the tick rate
// and writing every decremented value back to the same address.
module reg_countdown_seq #(
    parameter int NUM_REGS = reg_countdown_seq_pkg::NUM_REGS,
    parameter int DATA_W   = reg_countdown_seq_pkg::DATA_W,
    parameter int ADDR_W   = reg_countdown_seq_pkg::ADDR_W,
    parameter int TICK_DIV = reg_countdown_seq_pkg::TICK_DIV_DFLT
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Start,
    input  logic                Pause,
    reg_countdown_seq_if.master rf,
    output logic [DATA_W-1:0]   Count,
    output logic [ADDR_W-1:0]   Cur_Addr,
    output logic                Busy,
    output logic                Reg_Done,
    output logic                All_Done
);
    import reg_countdown_seq_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] count_q, count_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic              w_en_q, w_en_d;
    logic              presc_clr, presc_en, tick;

    assign presc_en = (state_q == ST_COUNT) && !Pause;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .Clk    (Clk),
        .Rst    (Rst),
        .clear  (presc_clr),
        .enable (presc_en),
        .tick   (tick)
    );

    assign rf.R_Addr = idx_q;
    assign rf.R_en   = (state_q == ST_READ);
    assign rf.W_Addr = w_addr_q;
    assign rf.W_en   = w_en_q;
    assign rf.W_Data = w_data_q;

    assign Count    = count_q;
    assign Cur_Addr = idx_q;
    assign Busy     = (state_q != ST_IDLE);
    assign Reg_Done = (state_q == ST_NEXT);
    assign All_Done = (state_q == ST_FINISH);

    // Next-state, index, countdown and write-back decode.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        count_d   = count_q;
        w_en_d    = 1'b0;
        w_addr_d  = w_addr_q;
        w_data_d  = w_data_q;
        presc_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (Start) state_d = ST_READ;
            end
            ST_READ: begin
                count_d   = rf.R_Data;
                presc_clr = 1'b1;
                state_d   = (rf.R_Data == '0) ? ST_NEXT : ST_COUNT;
            end
            ST_COUNT: begin
                // Count is nonzero here; the guard keeps it from ever wrapping.
                if (tick && (count_q != '0)) begin
                    count_d  = count_q - 1'b1;
                    w_en_d   = 1'b1;
                    w_addr_d = idx_q;
                    w_data_d = count_q - 1'b1;
                    if (count_q == DATA_W'(1)) state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_FINISH;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_READ;
                end
            end
            ST_FINISH: begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any walk with no pending write.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            count_q  <= '0;
            w_en_q   <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            w_en_q   <= w_en_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
        end
    end

endmodule
